div_cnt_prog: RTL and testbench

- Runtime-programmable integer clock divider. Parametrised successor to the fixed divide-by-4 `div_cnt`.
- Generates a divided clock `clk_out` from `clk`, plus a one-cycle `tick` strobe aligned to each `clk_out` rising edge.
- Divisor changes are applied only at a period boundary, so `clk_out` never produces a runt pulse.
- Sits in the clocking area: feeds slow-enable logic and the LED/UART sample-rate blocks.

---
 rtl/div_cnt_prog_if.sv | 21 ++
 rtl/div_cnt_prog.sv | 90 +++++++++
 tb/tb_div_cnt_prog.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/div_cnt_prog_if.sv
// rtl/div_cnt_prog_if.sv - control/status bundle for the programmable clock divider
interface div_cnt_prog_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic [CNT_W-1:0] div_cur;

  modport master (
    output en, div_in, div_load,
    input  clk_out, tick, div_cur
  );

  modport slave (
    input  en, div_in, div_load,
    output clk_out, tick, div_cur
  );
endinterface

// File: rtl/div_cnt_prog.sv
// rtl/div_cnt_prog.sv - runtime-programmable integer clock divider with tick strobe
// Optional 50% duty for odd divisors when DIV_CNT_PROG_ODD_DUTY50_EN is defined.
module div_cnt_prog #(
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 4
) (
  input logic           clk,
  input logic           rst,
  div_cnt_prog_if.slave bus
);
  localparam logic [CNT_W-1:0] DIV_RST = (DIV_DEFAULT < 2) ? CNT_W'(2) : CNT_W'(DIV_DEFAULT);

  function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] x);
    return (x < CNT_W'(2)) ? CNT_W'(2) : x;
  endfunction

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_cur;
  logic [CNT_W-1:0] pend;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] div_new;
  logic             pend_valid;
  logic             clk_out_reg;
  logic             tick_reg;
  logic             wrap;
  logic             half_hit;

  assign half     = div_cur >> 1;
  assign wrap     = bus.en && (cnt == div_cur - CNT_W'(1));
  assign half_hit = bus.en && (cnt == half - CNT_W'(1));
  assign div_new  = clamp(bus.div_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      clk_out_reg <= 1'b0;
      tick_reg    <= 1'b0;
      div_cur     <= DIV_RST;
      pend        <= '0;
      pend_valid  <= 1'b0;
    end else begin
      if (bus.en) begin
        cnt <= wrap ? '0 : cnt + CNT_W'(1);
      end

      if (wrap) begin
        clk_out_reg <= 1'b1;
      end else if (half_hit) begin
        clk_out_reg <= 1'b0;
      end

      tick_reg <= wrap;

      if (bus.div_load) begin
        pend       <= div_new;
        pend_valid <= 1'b1;
      end

      // A load on the wrap edge takes effect immediately and supersedes any pending value.
      if (wrap) begin
        if (bus.div_load) begin
          div_cur <= div_new;
        end else if (pend_valid) begin
          div_cur <= pend;
        end
        pend_valid <= 1'b0;
      end
    end
  end

`ifdef DIV_CNT_PROG_ODD_DUTY50_EN
  logic q_neg;

  // Half-cycle delayed copy stretches the high phase by half a clk period for odd divisors.
  always_ff @(negedge clk) begin
    if (rst) begin
      q_neg <= 1'b0;
    end else begin
      q_neg <= clk_out_reg;
    end
  end

  assign bus.clk_out = div_cur[0] ? (clk_out_reg | q_neg) : clk_out_reg;
`else
  assign bus.clk_out = clk_out_reg;
`endif

  assign bus.tick    = tick_reg;
  assign bus.div_cur = div_cur;
endmodule

// File: tb/tb_div_cnt_prog.sv
// tb/tb_div_cnt_prog.sv - self-checking bench for div_cnt_prog (vector table plus random vs. reference model)
module tb_div_cnt_prog;
  localparam int CNT_W = 8;
`ifdef DIV_CNT_PROG_ODD_DUTY50_EN
  localparam bit ODD_EN = 1'b1;
`else
  localparam bit ODD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #10 clk = ~clk;

  div_cnt_prog_if #(.CNT_W(CNT_W)) bus_if ();

  div_cnt_prog #(
    .CNT_W      (CNT_W),
    .DIV_DEFAULT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  typedef struct {
    bit rst;
    bit en;
    bit load;
    int din;
    bit e_clk;
    bit e_tick;
    int e_div;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: position within the current period, the divisor in force,
  // and whether the first (all-low) period after reset is still running.
  int m_div, m_pos, m_pend;
  bit m_pv, m_first, m_tick, m_clk, m_prev;

  function automatic int clampi(input int x);
    return (x < 2) ? 2 : x;
  endfunction

  function automatic bit out_exp(input bit reg_v, input bit prev_v, input int dv);
    return reg_v || (ODD_EN && prev_v && (dv % 2 == 1));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input bit l, input int d);
    bit wr;
    m_prev = m_clk;
    if (r) begin
      m_div = 4; m_pos = 0; m_pend = 0; m_pv = 0; m_first = 1; m_tick = 0;
    end else begin
      wr = e && (m_pos == m_div - 1);
      if (l) begin
        m_pend = clampi(d);
        m_pv   = 1;
      end
      if (wr) begin
        if (l) m_div = clampi(d);
        else if (m_pv) m_div = m_pend;
        m_pv = 0; m_pos = 0; m_first = 0; m_tick = 1;
      end else begin
        m_tick = 0;
        if (e) m_pos++;
      end
    end
    m_clk = !m_first && (m_pos < m_div / 2);
  endtask

  task automatic step(input bit r, input bit e, input bit l, input int d);
    rst             = r;
    bus_if.en       = e;
    bus_if.div_load = l;
    bus_if.div_in   = CNT_W'(d);
    @(posedge clk);
    model_edge(r, e, l, d);
    #1;
  endtask

  function automatic void add(input bit r, input bit e, input bit l, input int d,
                              input bit c, input bit t, input int dv);
    vecs.push_back('{r, e, l, d, c, t, dv});
  endfunction

  initial begin
    bit prev_e;
    bit r, e, l;
    int d;

    rst = 1'b1; bus_if.en = 1'b0; bus_if.div_load = 1'b0; bus_if.div_in = '0;

    for (int i = 0; i < 5; i++) add(1, 0, 0, 0, 0, 0, 4);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 4);
    add(0, 1, 0, 0, 1, 1, 4);
    add(0, 1, 0, 0, 1, 0, 4);
    add(0, 1, 0, 0, 0, 0, 4);
    add(0, 1, 1, 5, 0, 0, 4);
    add(0, 1, 0, 0, 1, 1, 5);
    add(0, 1, 0, 0, 1, 0, 5);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 5);
    add(0, 1, 0, 0, 1, 1, 5);
    add(0, 1, 1, 0, 1, 0, 5);
    add(0, 1, 1, 1, 0, 0, 5);
    add(0, 1, 0, 0, 0, 0, 5);
    add(0, 1, 0, 0, 0, 0, 5);
    add(0, 1, 0, 0, 1, 1, 2);
    add(0, 1, 0, 0, 0, 0, 2);
    add(0, 1, 0, 0, 1, 1, 2);
    add(0, 1, 0, 0, 0, 0, 2);
    add(0, 1, 1, 3, 1, 1, 3);
    add(0, 1, 1, 6, 0, 0, 3);
    add(0, 1, 1, 9, 0, 0, 3);
    add(0, 1, 0, 0, 1, 1, 9);
    add(0, 1, 0, 0, 1, 0, 9);
    add(0, 1, 0, 0, 1, 0, 9);
    add(0, 0, 0, 0, 1, 0, 9);
    add(0, 0, 1, 4, 1, 0, 9);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 1, 0, 9);
    add(0, 1, 0, 0, 1, 0, 9);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 0, 9);
    add(0, 1, 0, 0, 1, 1, 4);
    add(0, 1, 1, 7, 1, 0, 4);
    add(1, 1, 0, 0, 0, 0, 4);
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 4);
    add(0, 1, 0, 0, 1, 1, 4);

    prev_e = 1'b0;
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].din);
      chk($sformatf("vec%0d_clk_out", i), 32'(bus_if.clk_out),
          32'(out_exp(vecs[i].e_clk, prev_e, vecs[i].e_div)));
      chk($sformatf("vec%0d_tick", i), 32'(bus_if.tick), 32'(vecs[i].e_tick));
      chk($sformatf("vec%0d_div_cur", i), 32'(bus_if.div_cur), 32'(vecs[i].e_div));
      prev_e = vecs[i].e_clk;
    end

    step(1, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 249) == 0);
      e = ($urandom_range(0, 9) < 8);
      l = ($urandom_range(0, 24) == 0);
      d = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 9));
      step(r, e, l, d);
      chk("rnd_clk_out", 32'(bus_if.clk_out), 32'(out_exp(m_clk, m_prev, m_div)));
      chk("rnd_tick", 32'(bus_if.tick), 32'(m_tick));
      chk("rnd_div_cur", 32'(bus_if.div_cur), 32'(m_div));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
